if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch front end that drives the synchronous instruction memory and buffers returned {PC, instruction} pairs in a small FIFO.
- Feeds the IF/ID boundary of the 5-stage pipeline, decoupling fetch from decode stalls.
- Handles branch/jump redirects (the IF flush / PC-select path) by discarding queued and in-flight instructions and restarting at the target.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, value on id_inst when the queue is empty or in reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  fetch issued this cycle.
- imem_addr  out  32  fetch address; valid when imem_req=1.
- imem_rdata  in  32  instruction word; valid exactly one cycle after imem_req.
- redirect  in  1  flush plus PC redirect from ID/EX (taken branch or jump).
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 00.
- id_ready  in  1  decode accepts the head entry (deasserted on a load-use stall).
- id_valid  out  1  head entry valid.
- id_pc  out  32  PC of the head entry.
- id_inst  out  32  instruction of the head entry.
- q_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; queue empty; in-flight flag cleared.
  - imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=NOP_INST, q_count=0.
  - Asserting reset mid-operation drops all queued and in-flight fetches.
- Issue:
  - imem_req = reset && !redirect && (q_count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On an issue edge: fetch_pc += 4 (wraps modulo 2^32); inflight<=1 and inflight_pc<=fetch_pc.
  - If there is no issue, inflight<=0.
- Response:
  - While inflight=1, imem_rdata is pushed at the tail with inflight_pc.
  - Slot reservation guarantees a push never overflows. There is no push when full, and no drop.
- Output:
  - id_valid = (q_count != 0); id_pc/id_inst = head entry.
  - When empty: id_pc=0, id_inst=NOP_INST.
  - Pop on an edge with id_valid && id_ready.
  - Simultaneous push and pop leaves q_count unchanged.
  - Head and tail pointers wrap modulo DEPTH.
- Latency:
  - Issue at cycle N; push at the end of cycle N+1; id_valid at cycle N+2.
  - Back-to-back sustains 1 instruction/cycle when id_ready=1.
- Redirect (highest priority):
  - On the edge where redirect=1: queue cleared (q_count=0), in-flight response discarded, fetch_pc<=redirect_pc & ~3.
  - Pop and push in that cycle are suppressed. imem_req=0 during the redirect cycle.
  - The target instruction reaches id_valid 3 cycles after the redirect cycle.
  - Redirect held for multiple cycles: each cycle reloads fetch_pc and no fetch issues.
- Stall:
  - id_ready=0 holds the head stable.
  - Fetch continues until q_count + inflight = DEPTH, then imem_req=0.

Optional Feature:
- Macro: IF_FETCH_QUEUE_PERF_EN
- Defined:
  - Adds output perf_flush_cnt[31:0], incremented once per redirect cycle.
  - Adds output perf_bubble_cnt[31:0], incremented each cycle with id_ready=1 && id_valid=0.
  - Both counters reset to 0 on reset, wrap at 2^32, and do not count while reset is asserted.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Release reset, id_ready=1, imem returns mem[addr>>2] → imem_addr 0,4,8,… on consecutive cycles; first id_valid=1 two cycles after the first issue with id_pc=0; then one instruction per cycle with id_pc incrementing by 4.
- id_ready=0 for 10 cycles with DEPTH=4 → q_count saturates at 4, imem_req=0 once full, head id_pc unchanged; release → entries drain in order with no gaps and no duplicates.
- redirect=1 with redirect_pc=0x0000_0103 while the queue holds 3 entries and a fetch is in flight → next cycle q_count=0, id_valid=0, in-flight word never appears; imem_addr=0x100; id_pc=0x100 three cycles after redirect.
- Redirect and id_ready=1 with a pending push in the same cycle → no pop is observed, no stale entry afterwards; with the macro defined, perf_flush_cnt=1.
- Assert reset asynchronously between clock edges mid-stream → all outputs immediately take their reset values; after release, fetch restarts at RESET_PC=0.
- fetch_pc=0xFFFF_FFFC → next imem_addr=0x0000_0000 (wrap); the queue pointer wraps after 4 pushes with FIFO order preserved.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end. Issues sequential fetches to a synchronous
// instruction memory (one-cycle read latency) and buffers the returned
// {PC, instruction} pairs in a small FIFO that feeds the IF/ID boundary, so
// fetch keeps running while decode is stalled. A redirect from ID/EX flushes
// the queue and any in-flight fetch and restarts fetch at the target.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset (0 = reset)
//   imem_req       fetch issued this cycle
//   imem_addr      fetch address (current fetch PC)
//   imem_rdata     instruction word, valid one cycle after imem_req
//   redirect       flush + PC redirect (taken branch / jump)
//   redirect_pc    redirect target, bits [1:0] forced to 00
//   id_ready       decode accepts the head entry
//   id_valid       head entry valid
//   id_pc          PC of the head entry (0 when empty)
//   id_inst        instruction of the head entry (NOP_INST when empty)
//   q_count        number of occupied queue entries
//
// Optional feature (macro IF_FETCH_QUEUE_PERF_EN):
//   perf_flush_cnt   redirect cycles seen
//   perf_bubble_cnt  cycles where decode was ready but the queue was empty
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef IF_FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_flush_cnt,
    output logic [31:0]              perf_bubble_cnt
`endif
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [CW-1:0] occupied;
    logic          issue;
    logic          push;
    logic          pop;

    // A slot is reserved for the in-flight fetch, so counting it in the
    // occupancy guarantees every response has room when it returns.
    // Redirect suppresses issue, push and pop in the same cycle.
    always_comb begin
        occupied = q_count + CW'(inflight);
        issue    = reset && !redirect && (occupied < DEPTH_C);
        push     = inflight && !redirect;
        pop      = id_valid && id_ready && !redirect;
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign id_valid  = (q_count != '0);
    assign id_pc     = id_valid ? pc_mem[head] : 32'h0;
    assign id_inst   = id_valid ? inst_mem[head] : NOP_INST;

    // Fetch PC and in-flight tracking. The in-flight flag only lives for the
    // single cycle in which the memory returns data for the previous issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Queue pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two; a redirect empties the queue in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
        end else if (redirect) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only visible once q_count
    // covers it, and q_count is reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_mem[tail]   <= inflight_pc;
            inst_mem[tail] <= imem_rdata;
        end
    end

`ifdef IF_FETCH_QUEUE_PERF_EN
    // Performance counters: redirect cycles and decode-starved cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_flush_cnt  <= 32'h0;
            perf_bubble_cnt <= 32'h0;
        end else begin
            if (redirect) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (id_ready && !id_valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue (DEPTH=4). The memory model returns the
// bitwise complement of the fetch address one cycle after each request, so
// every queued instruction identifies the PC it came from.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        id_ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_count;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  q_count;
`ifdef IF_FETCH_QUEUE_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int total;
    int bad;

    vec_t tbl [24];

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .q_count     (q_count)
`ifdef IF_FETCH_QUEUE_PERF_EN
        ,
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: word at addr is ~addr.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= ~imem_addr;
        end
    end

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic req,
                                input logic [31:0] addr, input logic val,
                                input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.redirect    = rd;
        v.redirect_pc = rpc;
        v.id_ready    = rdy;
        v.exp_req     = req;
        v.exp_addr    = addr;
        v.exp_valid   = val;
        v.exp_pc      = pc;
        v.exp_count   = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare every visible output against one expected record.
    task automatic checkAll(input string tag, input vec_t v);
        logic [31:0] exp_inst;
        exp_inst = v.exp_valid ? ~v.exp_pc : NOP;
        checkOutput({tag, " imem_req"},  {31'b0, imem_req},  {31'b0, v.exp_req});
        checkOutput({tag, " imem_addr"}, imem_addr,          v.exp_addr);
        checkOutput({tag, " id_valid"},  {31'b0, id_valid},  {31'b0, v.exp_valid});
        checkOutput({tag, " id_pc"},     id_pc,              v.exp_pc);
        checkOutput({tag, " id_inst"},   id_inst,            exp_inst);
        checkOutput({tag, " q_count"},   {29'b0, q_count},   {29'b0, v.exp_count});
    endtask

    // Drive one cycle's inputs shortly after a rising edge, check the
    // settled outputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        redirect    = v.redirect;
        redirect_pc = v.redirect_pc;
        id_ready    = v.id_ready;
        #2;
        checkAll(tag, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        //             rd  rpc           rdy req addr          val pc            cnt
        tbl[0]  = mk(0, 32'h0,        1,  1, 32'h0000_0000, 0, 32'h0,        3'd0);
        tbl[1]  = mk(0, 32'h0,        1,  1, 32'h0000_0004, 0, 32'h0,        3'd0);
        tbl[2]  = mk(0, 32'h0,        1,  1, 32'h0000_0008, 1, 32'h0000_0000, 3'd1);
        tbl[3]  = mk(0, 32'h0,        1,  1, 32'h0000_000C, 1, 32'h0000_0004, 3'd1);
        tbl[4]  = mk(0, 32'h0,        1,  1, 32'h0000_0010, 1, 32'h0000_0008, 3'd1);
        tbl[5]  = mk(0, 32'h0,        0,  1, 32'h0000_0014, 1, 32'h0000_000C, 3'd1);
        tbl[6]  = mk(0, 32'h0,        0,  1, 32'h0000_0018, 1, 32'h0000_000C, 3'd2);
        tbl[7]  = mk(0, 32'h0,        0,  0, 32'h0000_001C, 1, 32'h0000_000C, 3'd3);
        tbl[8]  = mk(0, 32'h0,        0,  0, 32'h0000_001C, 1, 32'h0000_000C, 3'd4);
        tbl[9]  = mk(0, 32'h0,        0,  0, 32'h0000_001C, 1, 32'h0000_000C, 3'd4);
        tbl[10] = mk(0, 32'h0,        1,  0, 32'h0000_001C, 1, 32'h0000_000C, 3'd4);
        tbl[11] = mk(0, 32'h0,        1,  1, 32'h0000_001C, 1, 32'h0000_0010, 3'd3);
        tbl[12] = mk(0, 32'h0,        1,  1, 32'h0000_0020, 1, 32'h0000_0014, 3'd2);
        tbl[13] = mk(0, 32'h0,        1,  1, 32'h0000_0024, 1, 32'h0000_0018, 3'd2);
        tbl[14] = mk(0, 32'h0,        0,  1, 32'h0000_0028, 1, 32'h0000_001C, 3'd2);
        tbl[15] = mk(1, 32'h0000_0103, 0, 0, 32'h0000_002C, 1, 32'h0000_001C, 3'd3);
        tbl[16] = mk(0, 32'h0,        1,  1, 32'h0000_0100, 0, 32'h0,        3'd0);
        tbl[17] = mk(0, 32'h0,        1,  1, 32'h0000_0104, 0, 32'h0,        3'd0);
        tbl[18] = mk(0, 32'h0,        1,  1, 32'h0000_0108, 1, 32'h0000_0100, 3'd1);
        tbl[19] = mk(1, 32'hFFFF_FFFC, 1, 0, 32'h0000_010C, 1, 32'h0000_0104, 3'd1);
        tbl[20] = mk(0, 32'h0,        1,  1, 32'hFFFF_FFFC, 0, 32'h0,        3'd0);
        tbl[21] = mk(0, 32'h0,        1,  1, 32'h0000_0000, 0, 32'h0,        3'd0);
        tbl[22] = mk(0, 32'h0,        1,  1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 3'd1);
        tbl[23] = mk(0, 32'h0,        1,  1, 32'h0000_0008, 1, 32'h0000_0000, 3'd1);

        // Power-on reset: outputs must show reset values while held.
        #1 reset = 1'b0;
        #2;
        checkAll("por", mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 3'd0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Stream, stall to full, drain, redirect with in-flight data,
        // redirect to 0xFFFF_FFFC and address wrap.
        for (int i = 0; i < 24; i++) begin
            applyStimulus($sformatf("vec%0d", i), tbl[i]);
        end

`ifdef IF_FETCH_QUEUE_PERF_EN
        checkOutput("perf_flush", perf_flush_cnt, 32'd2);
        checkOutput("perf_bubble", perf_bubble_cnt, 32'd6);
`endif

        // Asynchronous reset between edges while the queue holds an entry
        // and a fetch is in flight.
        id_ready = 1'b1;
        #3 reset = 1'b0;
        #1;
        checkAll("async_rst", mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 3'd0));
`ifdef IF_FETCH_QUEUE_PERF_EN
        checkOutput("perf_flush_rst", perf_flush_cnt, 32'd0);
        checkOutput("perf_bubble_rst", perf_bubble_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        checkAll("rst_held", mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 3'd0));
        reset = 1'b1;

        // Fetch restarts at RESET_PC with the same two-cycle latency.
        applyStimulus("restart0", mk(0, 32'h0, 1, 1, 32'h0000_0000, 0, 32'h0, 3'd0));
        applyStimulus("restart1", mk(0, 32'h0, 1, 1, 32'h0000_0004, 0, 32'h0, 3'd0));
        applyStimulus("restart2", mk(0, 32'h0, 1, 1, 32'h0000_0008, 1, 32'h0, 3'd1));
        applyStimulus("restart3", mk(0, 32'h0, 1, 1, 32'h0000_000C, 1, 32'h4, 3'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
